// File: rtl/gpu_pkg.sv
// Shared GPU definitions: instruction width, field layout and default
// instruction FIFO depth.
package gpu_pkg;

    localparam int INST_WIDTH = 82;
    localparam int INST_DEPTH = 16;

    // Field widths, LSB-first packing of the 82-bit host instruction.
    localparam int FILL_TYPE_W   = 1;
    localparam int INST_TYPE_W   = 3;
    localparam int VERTICE_W     = 2;
    localparam int LAYER_W       = 4;
    localparam int COLOR_W       = 24;
    localparam int TEXTURE_W     = 4;
    localparam int ALPHA_W       = 8;
    localparam int COORDINATES_W = 36;

    // Field offsets (bit position of each field's LSB).
    localparam int FILL_TYPE_LSB   = 0;
    localparam int INST_TYPE_LSB   = FILL_TYPE_LSB + FILL_TYPE_W;
    localparam int VERTICE_LSB     = INST_TYPE_LSB + INST_TYPE_W;
    localparam int LAYER_LSB       = VERTICE_LSB + VERTICE_W;
    localparam int COLOR_LSB       = LAYER_LSB + LAYER_W;
    localparam int TEXTURE_LSB     = COLOR_LSB + COLOR_W;
    localparam int ALPHA_LSB       = TEXTURE_LSB + TEXTURE_W;
    localparam int COORDINATES_LSB = ALPHA_LSB + ALPHA_W;

    // Packed view of one instruction; declaration order is MSB first.
    typedef struct packed {
        logic [COORDINATES_W-1:0] coordinates;
        logic [ALPHA_W-1:0]       alpha;
        logic [TEXTURE_W-1:0]     texture;
        logic [COLOR_W-1:0]       color;
        logic [LAYER_W-1:0]       layer;
        logic [VERTICE_W-1:0]     vertice;
        logic [INST_TYPE_W-1:0]   inst_type;
        logic [FILL_TYPE_W-1:0]   fill_type;
    } inst_t;

    // Reinterpret a raw instruction word as its field view.
    function automatic inst_t to_inst(input logic [INST_WIDTH-1:0] raw);
        return inst_t'(raw);
    endfunction

endpackage

// File: rtl/inst_fifo_mem.sv
// Instruction FIFO storage: DEPTH x DATA_WIDTH register array with one
// synchronous write port and one asynchronous read port. Contents are not
// reset; the FIFO masks the read data while empty.
module inst_fifo_mem #(
    parameter int DATA_WIDTH = 82,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Store the incoming instruction at the write index.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Asynchronous read of the head slot.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/inst_fifo.sv
// Show-ahead instruction FIFO feeding the GPU core decode block.
// Optional status outputs (count, sticky overflow/underflow) are built when
// INST_FIFO_STATUS_EN is defined.
module inst_fifo
    import gpu_pkg::*;
#(
    parameter int DATA_WIDTH = INST_WIDTH,
    parameter int DEPTH      = INST_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  w_enable,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  r_enable,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  empty,
    output logic                  full
`ifdef INST_FIFO_STATUS_EN
    ,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_WIDTH:0]   wptr;
    logic [ADDR_WIDTH:0]   rptr;
    logic                  w_accept;
    logic                  r_accept;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Flags come straight from the pointer registers.
    always_comb begin
        empty = (wptr == rptr);
        full  = (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]) &&
                (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);
    end

    // Gate requests against the current flags; full blocks writes even when a
    // read is accepted on the same edge (no pass-through).
    always_comb begin
        w_accept = w_enable && !full;
        r_accept = r_enable && !empty;
    end

    // Pointer advance; reset discards every entry at once.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (w_accept) wptr <= wptr + 1'b1;
            if (r_accept) rptr <= rptr + 1'b1;
        end
    end

    inst_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_accept),
        .waddr (wptr[ADDR_WIDTH-1:0]),
        .wdata (w_data),
        .raddr (rptr[ADDR_WIDTH-1:0]),
        .rdata (mem_rdata)
    );

    // Head entry, masked so stale storage never shows while empty.
    always_comb begin
        r_data = empty ? '0 : mem_rdata;
    end

`ifdef INST_FIFO_STATUS_EN
    // Occupancy: pointer difference naturally lands in 0..DEPTH.
    always_comb begin
        count = wptr - rptr;
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_enable && full)  overflow  <= 1'b1;
            if (r_enable && empty) underflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fifo.sv
// Testbench for inst_fifo: vector table plus scoreboard-driven sequences.
module tb_inst_fifo;

    localparam int DW    = 82;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          w_enable = 1'b0;
    logic [DW-1:0] w_data = '0;
    logic          r_enable = 1'b0;
    logic [DW-1:0] r_data;
    logic          empty;
    logic          full;
`ifdef INST_FIFO_STATUS_EN
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [DW-1:0] sb[$];

    always #5 clk = ~clk;

    inst_fifo dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .w_enable  (w_enable),
        .w_data    (w_data),
        .r_enable  (r_enable),
        .r_data    (r_data),
        .empty     (empty),
        .full      (full)
`ifdef INST_FIFO_STATUS_EN
        ,
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    typedef struct {
        logic          we;
        logic [DW-1:0] wd;
        logic          re;
        logic          e_empty;
        logic          e_full;
        logic [DW-1:0] e_rdata;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the scoreboard model.
    task automatic chk_state(input string tag);
        logic [DW-1:0] head;
        head = (sb.size() > 0) ? sb[0] : '0;
        chk({tag, ".empty"}, DW'(empty), DW'(sb.size() == 0));
        chk({tag, ".full"}, DW'(full), DW'(sb.size() == DEPTH));
        chk({tag, ".r_data"}, r_data, head);
`ifdef INST_FIFO_STATUS_EN
        chk({tag, ".count"}, DW'(count), DW'(sb.size()));
        chk({tag, ".overflow"}, DW'(overflow), DW'(m_ovf));
        chk({tag, ".underflow"}, DW'(underflow), DW'(m_unf));
`endif
    endtask

    // One clock of stimulus; accepted reads are scored against the queue head.
    task automatic step(input logic we, input logic [DW-1:0] wd, input logic re, input string tag);
        logic          wacc;
        logic          racc;
        logic [DW-1:0] head;
        @(negedge clk);
        w_enable = we;
        w_data   = wd;
        r_enable = re;
        wacc = we && (sb.size() < DEPTH);
        racc = re && (sb.size() > 0);
`ifdef INST_FIFO_STATUS_EN
        if (we && sb.size() == DEPTH) m_ovf = 1'b1;
        if (re && sb.size() == 0)     m_unf = 1'b1;
`endif
        if (racc) begin
            head = sb.pop_front();
            #1 chk({tag, ".pop"}, r_data, head);
        end
        if (wacc) sb.push_back(wd);
        @(posedge clk);
        #1;
        w_enable = 1'b0;
        r_enable = 1'b0;
        chk_state(tag);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".empty"}, DW'(empty), DW'(1));
        chk({tag, ".full"}, DW'(full), DW'(0));
        chk({tag, ".r_data"}, r_data, '0);
`ifdef INST_FIFO_STATUS_EN
        chk({tag, ".count"}, DW'(count), DW'(0));
        chk({tag, ".overflow"}, DW'(overflow), DW'(0));
        chk({tag, ".underflow"}, DW'(underflow), DW'(0));
`endif
    endtask

    // Asynchronous reset pulse in the middle of a low clock phase.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        #2 n_rst = 1'b0;
        #1 chk_reset_vals(tag);
        sb.delete();
`ifdef INST_FIFO_STATUS_EN
        m_ovf = 1'b0;
        m_unf = 1'b0;
`endif
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    initial begin
        tbl[0] = '{1'b1, 82'h1_2345, 1'b0, 1'b0, 1'b0, 82'h1_2345};
        tbl[1] = '{1'b0, 82'h0,      1'b0, 1'b0, 1'b0, 82'h1_2345};
        tbl[2] = '{1'b0, 82'h0,      1'b1, 1'b1, 1'b0, 82'h0};
        tbl[3] = '{1'b0, 82'h0,      1'b1, 1'b1, 1'b0, 82'h0};
        tbl[4] = '{1'b1, 82'h5,      1'b0, 1'b0, 1'b0, 82'h5};
        tbl[5] = '{1'b1, 82'h6,      1'b1, 1'b0, 1'b0, 82'h6};
        tbl[6] = '{1'b0, 82'h0,      1'b1, 1'b1, 1'b0, 82'h0};

        #3 chk_reset_vals("reset0");
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_vals("idle");

        // Vector table: explicit expectations on top of the model checks.
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].we, tbl[i].wd, tbl[i].re, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.t_empty", i), DW'(empty), DW'(tbl[i].e_empty));
            chk($sformatf("vec%0d.t_full", i), DW'(full), DW'(tbl[i].e_full));
            chk($sformatf("vec%0d.t_rdata", i), r_data, tbl[i].e_rdata);
        end

        // Fill to full, overflow attempt, drain in order.
        pulse_reset("reset1");
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, DW'(i), 1'b0, $sformatf("fill%0d", i));
            chk($sformatf("fill%0d.t_full", i), DW'(full), DW'(i == 16));
        end
        step(1'b1, DW'(99), 1'b0, "ovf_write");
        chk("ovf_write.t_full", DW'(full), DW'(1));
`ifdef INST_FIFO_STATUS_EN
        chk("ovf_write.t_overflow", DW'(overflow), DW'(1));
`endif
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("drain%0d.t_head", i), r_data, DW'(i));
            step(1'b0, '0, 1'b1, $sformatf("drain%0d", i));
        end
        chk("drain.t_empty", DW'(empty), DW'(1));

        // Steady-state streaming across pointer wrap.
        pulse_reset("reset2");
        for (int i = 0; i < 8; i++) step(1'b1, DW'(100 + i), 1'b0, $sformatf("hold%0d", i));
        for (int i = 0; i < 20; i++) begin
            step(1'b1, DW'(200 + i), 1'b1, $sformatf("stream%0d", i));
            chk($sformatf("stream%0d.t_occ", i), DW'(sb.size()), DW'(8));
        end
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, $sformatf("flush%0d", i));

        // Simultaneous write and read on an empty FIFO.
        pulse_reset("reset3");
        step(1'b1, DW'(7), 1'b1, "wr_on_empty");
        chk("wr_on_empty.t_rdata", r_data, DW'(7));
`ifdef INST_FIFO_STATUS_EN
        chk("wr_on_empty.t_count", DW'(count), DW'(1));
        chk("wr_on_empty.t_underflow", DW'(underflow), DW'(1));
`endif

        // Reset while holding entries, then reuse.
        for (int i = 0; i < 5; i++) step(1'b1, DW'(50 + i), 1'b0, $sformatf("pre%0d", i));
        pulse_reset("reset4");
        step(1'b1, DW'(42), 1'b0, "post_rst_wr");
        chk("post_rst_wr.t_rdata", r_data, DW'(42));
        step(1'b0, '0, 1'b1, "post_rst_rd");
        chk("post_rst_rd.t_empty", DW'(empty), DW'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inst_fifo.md
# inst_fifo

Instruction FIFO sitting directly upstream of the GPU core wrapper. It buffers 82-bit host drawing instructions and presents the head entry in show-ahead form on `r_data`, so the combinational decode block sees it without a read cycle. The main controller's `read_en` pops the entry; `empty` feeds the controller's `fifo_empty`.

## Interface
Parameters:
- `DATA_WIDTH`, default 82: instruction width; matches the decode input.
- `DEPTH`, default 16: number of entries; must be a power of 2 and at least 2.
- `ADDR_WIDTH`, default $clog2(DEPTH): pointer index width. Derived; never overridden.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `w_enable`  in  1  host write request.
- `w_data`  in  DATA_WIDTH  instruction to enqueue.
- `r_enable`  in  1  pop request, driven by the main controller's `read_en`.
- `r_data`  out  DATA_WIDTH  head entry (show-ahead); 0 when empty.
- `empty`  out  1  no valid entries.
- `full`  out  1  DEPTH valid entries.
- `count`  out  ADDR_WIDTH+1  occupancy. Present only with `INST_FIFO_STATUS_EN`.
- `overflow`  out  1  sticky: a write was attempted while full. Present only with `INST_FIFO_STATUS_EN`.
- `underflow`  out  1  sticky: a read was attempted while empty. Present only with `INST_FIFO_STATUS_EN`.

## Operation
- Storage: DEPTH×DATA_WIDTH register array. Pointers `wptr` and `rptr` are ADDR_WIDTH+1 bits wide; the MSB is a wrap bit.
- `empty` = (`wptr` == `rptr`).
- `full` = index bits equal and wrap bits differ.
- Write accepted iff `w_enable` && !`full`. An accepted write stores `w_data` at mem[`wptr`[ADDR_WIDTH-1:0]] and increments `wptr`.
- Read accepted iff `r_enable` && !`empty`. An accepted read increments `rptr`. The data was already on `r_data` before the edge.
- `r_data` = `empty` ? 0 : mem[`rptr` index]. This path is combinational from registers.
- Pointers wrap naturally modulo 2·DEPTH. No other wrap logic is needed.
- Simultaneous write and read:
  - Not full and not empty: both accepted; occupancy unchanged.
  - Empty: only the write is accepted; the read is ignored (counts as underflow).
  - Full: only the read is accepted; the write is dropped (counts as overflow). No pass-through.
- Dropped writes and ignored reads never corrupt pointers or contents.
- Reset mid-operation: pointers clear immediately and all entries are discarded. Memory contents are not reset; they are unobservable because `r_data` is masked while empty.

## Timing
- Reset values: `r_data`=0, `empty`=1, `full`=0, `count`=0, `overflow`=0, `underflow`=0.
- Write latency: a write accepted at edge N makes the entry visible on `r_data` and deasserts `empty` after edge N (one cycle).
- Read: `r_data` advances to the next entry (or 0) after the accepting edge.
- `full` asserts after the edge that accepts the DEPTH-th unread write. It deasserts after the next accepted read.
- All flags are registered-derived, with no combinational path from `w_enable`/`r_enable` to any output.

## Configuration
- Macro: `INST_FIFO_STATUS_EN`.
- Defined:
  - `count` = `wptr` − `rptr` (ADDR_WIDTH+1 bits, range 0..DEPTH).
  - `overflow` sets on any edge with `w_enable`&&`full`.
  - `underflow` sets on any edge with `r_enable`&&`empty`.
  - Both flags are sticky until `n_rst`.
- Undefined: `count`, `overflow` and `underflow` ports and logic are absent. FIFO behaviour is otherwise identical.

## Structure
- Shared package `gpu_pkg`:
  - `INST_WIDTH`=82.
  - Instruction field offsets: coordinates, alpha, texture, color, layer, vertice, inst_type, fill_type.
  - `inst_t` packed typedef.
  - Default `INST_DEPTH`=16.
- One sub-module, `inst_fifo_mem`: register array with write port and asynchronous read port.
- Pointer and flag logic stays in `inst_fifo`.

## Test plan
- Reset, then idle → `empty`=1, `full`=0, `r_data`=0; with macro, `count`=0.
- Write 82'h1_2345 → next cycle `empty`=0, `r_data`=82'h1_2345. Pop once → `empty`=1, `r_data`=0.
- Write 16 distinct values 1..16 → `full`=1 after the 16th write. A 17th write (value 99) is dropped and `overflow`=1. Pop 16 → values 1..16 in order, and 99 never appears.
- Hold 8 entries, then assert `w_enable`+`r_enable` together for 20 cycles → occupancy stays 8 and output order is preserved across pointer wrap.
- Empty FIFO with simultaneous write(7) and read → `r_data`=7 next cycle, `count`=1, `underflow`=1.
- Fill 5 entries, pulse `n_rst` low mid-cycle → outputs return immediately to reset values; the next write is read back correctly.
